step_watchdog: RTL and testbench
================================

Name: step_watchdog

Overview:
- Safety monitor that sits directly downstream of the command block's step outputs.
- Tracks per-channel step inactivity and arms from an external endstop level.
- Latches a shutdown request that is fed back into command.req_shutdown.
- Also drives the board watchdog strobe (wdi) while the system is healthy.

Parameters:
- NSTEPDIR, 6: number of step channels monitored.
- CNT_BITS, 32: idle counter width.
- TIMEOUT, 480000000: idle cycles before a channel alerts (10 s at 48 MHz). Must be < 2^CNT_BITS.
- WATCH_MASK, 6'b100000: channels whose alert trips shutdown; must be NSTEPDIR bits wide.
- WDI_HALF, 2400000: wdi half-period in cycles (optional feature only).

Ports:
- clk  in  1  system clock (the only clock).
- rst  in  1  synchronous, active-high reset.
- step  in  NSTEPDIR  step levels from command.
- arm_n  in  1  asynchronous endstop level; low arms the watchdog.
- clr  in  1  one-cycle pulse; clears the trip latch and disarms.
- alert  out  NSTEPDIR  per-channel idle-timeout flags.
- armed  out  1  watchdog armed.
- req_shutdown  out  1  latched shutdown request.
- idle_dbg  out  8  bits [CNT_BITS-1:CNT_BITS-8] of the highest-index channel counter.
- wdi  out  1  external watchdog strobe.

Behaviour:
- Reset: rst is synchronous and active-high, sampled on posedge clk. While rst is high, and in the cycle after, all of the following are 0: counters, prev_step, sync flops, alert, armed, req_shutdown, wdi, idle_dbg. State goes to DISARMED.
- Edge detect: prev_step[i] <= step[i] every cycle. Any toggle (prev_step[i] != step[i]) is activity; both edges count.
- Counter i:
  - Activity: cnt <= 0. This has priority over increment and saturation.
  - Else if cnt != TIMEOUT: cnt <= cnt + 1.
  - Else: hold at TIMEOUT. The counter never wraps.
- alert[i] is registered: alert[i] <= (cnt == TIMEOUT) && !activity. It rises exactly TIMEOUT+1 cycles after the last toggle, and drops the cycle after a toggle is seen.
- arm_n passes through a 2-flop synchronizer; arm_s is the synchronized value.
- FSM (state encoded in the package):
  - DISARMED -> ARMED when arm_s == 0.
  - ARMED -> TRIPPED when |(alert & WATCH_MASK).
  - TRIPPED holds until clr or rst.
  - clr in any state -> DISARMED. clr wins over a simultaneous trip or arm condition in the same cycle.
  - After clr, re-arming needs arm_s low again (it may already be low, giving the next cycle).
- Outputs from state:
  - armed = (state != DISARMED).
  - req_shutdown = (state == TRIPPED), registered. It asserts one cycle after the alert bit is seen.
  - Alerts while DISARMED are reported on alert but never trip.
- Simultaneous events:
  - Activity on a watched channel in the same cycle its alert is high: the FSM samples the registered alert, so the trip still occurs.
  - Multiple channels alerting together: a single trip.
- idle_dbg is registered from counter NSTEPDIR-1, giving 1 cycle latency.

Optional Feature:
- Macro: STEP_WATCHDOG_WDI_EN.
- Defined:
  - A WDI_HALF-cycle counter toggles wdi each time it reaches WDI_HALF-1, then resets to 0.
  - Toggling runs only when state != TRIPPED. In TRIPPED, wdi freezes at its current level so the external supervisor times out.
  - rst clears the counter and wdi.
- Undefined: wdi is tied to 0, no counter is synthesised, and the port remains.

Decomposition:
- Shared package conan_pkg holds:
  - wd_state_t enum {WD_DISARMED, WD_ARMED, WD_TRIPPED}.
  - Constant WD_DEFAULT_TIMEOUT = HZ*10.
- Sub-module step_idle_counter, instantiated NSTEPDIR times via generate. It holds the edge detect, saturating counter and registered alert, with parameters CNT_BITS and TIMEOUT.
- The FSM, synchronizer and wdi generator stay in step_watchdog.

Test Plan (all with TIMEOUT=100, WDI_HALF=10, WATCH_MASK=6'b100000):
- rst high 3 cycles, then low; step static, arm_n=1 -> alert[i] rises at cycle 101 after reset release; armed=0; req_shutdown stays 0.
- Toggle step[5] every 50 cycles, arm_n=0 -> armed=1 after 3 cycles; alert[5] never rises; req_shutdown=0 throughout.
- Armed; stop step[5]; step[0..4] toggling -> alert[5] at +101 cycles; req_shutdown=1 on the following cycle; step[5] toggles afterward leave req_shutdown=1.
- Tripped; pulse clr with arm_n=1 -> next cycle armed=0, req_shutdown=0. Then set arm_n=0 -> re-armed after 3 cycles and re-trips if step[5] is still idle.
- clr in the same cycle alert[5] first rises while ARMED -> state DISARMED, req_shutdown never asserts.
- With STEP_WATCHDOG_WDI_EN defined: wdi period is 20 cycles while ARMED; after a trip, wdi is constant for 200 cycles. Without the macro: wdi=0 always.

Source files
------------

// File: rtl/conan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conan_pkg
// Description : Shared constants and watchdog state encoding for the
//               step-safety slice.
// Revision    : 1.0 - initial release
// ============================================================================
package conan_pkg;

    localparam int unsigned HZ                 = 48_000_000;
    localparam int unsigned WD_DEFAULT_TIMEOUT = HZ * 10;

    typedef enum logic [1:0] {
        WD_DISARMED = 2'd0,
        WD_ARMED    = 2'd1,
        WD_TRIPPED  = 2'd2
    } wd_state_t;

endpackage
`default_nettype wire

// File: rtl/step_watchdog_idle_counter.sv
`default_nettype none
// ============================================================================
// Module      : step_idle_counter
// Description : Per-channel step edge detector with a saturating idle counter
//               and registered idle-timeout alert.
// Revision    : 1.0 - initial release
// ============================================================================
module step_idle_counter
    import conan_pkg::*;
#(
    parameter int          CNT_BITS = 32,
    parameter int unsigned TIMEOUT  = WD_DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    output logic                alert,
    output logic [CNT_BITS-1:0] cnt
);

    localparam logic [CNT_BITS-1:0] c_timeout = CNT_BITS'(TIMEOUT);

    logic                r_prev_step;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_alert;
    logic                w_activity;
    logic                w_at_limit;

    // Both step edges count as activity.
    assign w_activity = r_prev_step ^ step;
    assign w_at_limit = (r_cnt == c_timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_step <= 1'b0;
            r_cnt       <= '0;
            r_alert     <= 1'b0;
        end else begin
            r_prev_step <= step;
            if (w_activity) begin
                r_cnt <= '0;
            end else if (!w_at_limit) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_alert <= w_at_limit && !w_activity;
        end
    end

    assign alert = r_alert;
    assign cnt   = r_cnt;

endmodule
`default_nettype wire

// File: rtl/step_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : step_watchdog
// Description : Step-inactivity safety monitor: per-channel idle alerts, an
//               endstop-armed trip latch driving req_shutdown, and an optional
//               board watchdog strobe (macro STEP_WATCHDOG_WDI_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module step_watchdog
    import conan_pkg::*;
#(
    parameter int                   NSTEPDIR   = 6,
    parameter int                   CNT_BITS   = 32,
    parameter int unsigned          TIMEOUT    = WD_DEFAULT_TIMEOUT,
    parameter logic [NSTEPDIR-1:0]  WATCH_MASK = 6'b100000,
    parameter int unsigned          WDI_HALF   = 2_400_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSTEPDIR-1:0] step,
    input  logic                arm_n,
    input  logic                clr,
    output logic [NSTEPDIR-1:0] alert,
    output logic                armed,
    output logic                req_shutdown,
    output logic [7:0]          idle_dbg,
    output logic                wdi
);

    if (CNT_BITS < 8) begin : g_chk_cnt_bits
        $error("step_watchdog: CNT_BITS must be at least 8");
    end
    if (64'(TIMEOUT) >= (64'd1 << CNT_BITS)) begin : g_chk_timeout
        $error("step_watchdog: TIMEOUT must be below 2**CNT_BITS");
    end
    if (WDI_HALF < 2) begin : g_chk_wdi_half
        $error("step_watchdog: WDI_HALF must be at least 2");
    end

    logic [NSTEPDIR-1:0] w_alert;
    logic [CNT_BITS-1:0] w_cnt [NSTEPDIR];
    logic [7:0]          r_idle_dbg;
    logic                r_arm_meta;
    logic                r_arm_sync;
    wd_state_t           r_state;
    wd_state_t           w_state_next;

    for (genvar gi = 0; gi < NSTEPDIR; gi++) begin : g_chan
        step_idle_counter #(
            .CNT_BITS (CNT_BITS),
            .TIMEOUT  (TIMEOUT)
        ) u_idle (
            .clk   (clk),
            .rst   (rst),
            .step  (step[gi]),
            .alert (w_alert[gi]),
            .cnt   (w_cnt[gi])
        );
    end

    assign alert = w_alert;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_dbg <= 8'd0;
        end else begin
            r_idle_dbg <= w_cnt[NSTEPDIR-1][CNT_BITS-1 -: 8];
        end
    end

    assign idle_dbg = r_idle_dbg;

    // The synchronizer carries the inverted endstop level so that the
    // all-zero reset value means "not arming" rather than a spurious arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arm_meta <= 1'b0;
            r_arm_sync <= 1'b0;
        end else begin
            r_arm_meta <= ~arm_n;
            r_arm_sync <= r_arm_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WD_DISARMED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // clr outranks any arm or trip condition seen in the same cycle.
    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = WD_DISARMED;
        end else begin
            case (r_state)
                WD_DISARMED: if (r_arm_sync) w_state_next = WD_ARMED;
                WD_ARMED:    if (|(w_alert & WATCH_MASK)) w_state_next = WD_TRIPPED;
                WD_TRIPPED:  w_state_next = WD_TRIPPED;
                default:     w_state_next = WD_DISARMED;
            endcase
        end
    end

    always_comb begin
        armed        = (r_state != WD_DISARMED);
        req_shutdown = (r_state == WD_TRIPPED);
    end

`ifdef STEP_WATCHDOG_WDI_EN
    localparam int c_wdi_bits = (WDI_HALF > 1) ? $clog2(WDI_HALF) : 1;
    localparam logic [c_wdi_bits-1:0] c_wdi_last = c_wdi_bits'(WDI_HALF - 1);

    logic [c_wdi_bits-1:0] r_wdi_cnt;
    logic                  r_wdi;

    // Freezing in TRIPPED lets the external supervisor time out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdi_cnt <= '0;
            r_wdi     <= 1'b0;
        end else if (r_state != WD_TRIPPED) begin
            if (r_wdi_cnt == c_wdi_last) begin
                r_wdi_cnt <= '0;
                r_wdi     <= ~r_wdi;
            end else begin
                r_wdi_cnt <= r_wdi_cnt + 1'b1;
            end
        end
    end

    assign wdi = r_wdi;
`else
    assign wdi = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_step_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_watchdog
// Description : Scoreboard-driven bench for step_watchdog (TIMEOUT=100,
//               WDI_HALF=10, WATCH_MASK=6'b100000, CNT_BITS=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_watchdog;

    localparam int NSTEPDIR = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic [NSTEPDIR-1:0] step;
    logic                arm_n;
    logic                clr;
    logic [NSTEPDIR-1:0] alert;
    logic                armed;
    logic                req_shutdown;
    logic [7:0]          idle_dbg;
    logic                wdi;

    step_watchdog #(
        .NSTEPDIR   (NSTEPDIR),
        .CNT_BITS   (8),
        .TIMEOUT    (100),
        .WATCH_MASK (6'b100000),
        .WDI_HALF   (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .step         (step),
        .arm_n        (arm_n),
        .clr          (clr),
        .alert        (alert),
        .armed        (armed),
        .req_shutdown (req_shutdown),
        .idle_dbg     (idle_dbg),
        .wdi          (wdi)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    value;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   obs;
    int   checks = 0;
    int   errors = 0;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int rise = -1, rise_val = 0, dbg_mid = -1, arm_seen = 0, req_seen = 0, wdi_seen = 0;
        rst = 1'b1; step = '0; arm_n = 1'b1; clr = 1'b0;
        tick(3);
        sb.push_back('{"rst_alert", 0});
        sb.push_back('{"rst_armed", 0});
        sb.push_back('{"rst_req", 0});
        sb.push_back('{"rst_idle_dbg", 0});
        obs = int'(alert);        e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = int'(armed);        e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = int'(req_shutdown); e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = int'(idle_dbg);     e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        rst = 1'b0;
        tick(1);
        sb.push_back('{"post_rst_alert_idle_dbg", 0});
        obs = int'(alert) | int'(idle_dbg) | int'(armed); e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        sb.push_back('{"alert_rise_cycle", 101});
        sb.push_back('{"alert_rise_value", 63});
        sb.push_back('{"idle_dbg_cycle50", 49});
        sb.push_back('{"idle_dbg_saturated", 100});
        sb.push_back('{"disarmed_armed_seen", 0});
        sb.push_back('{"disarmed_req_seen", 0});
        for (int n = 2; n <= 200; n++) begin
            tick(1);
            if (alert != '0 && rise < 0) begin rise = n; rise_val = int'(alert); end
            if (n == 50) dbg_mid = int'(idle_dbg);
            if (armed) arm_seen++;
            if (req_shutdown) req_seen++;
            if (wdi) wdi_seen++;
        end
        obs = rise;            e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = rise_val;        e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = dbg_mid;         e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = int'(idle_dbg);  e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = arm_seen;        e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = req_seen;        e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
`ifndef STEP_WATCHDOG_WDI_EN
        sb.push_back('{"wdi_tied_low_disarmed", 0});
        obs = wdi_seen;        e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
`endif
    endtask

    task automatic test_arm_activity();
        int arm_at = -1, a5_seen = 0, req_seen = 0, wdi_seen = 0, r1 = -1, r2 = -1;
        logic prev_wdi;
        prev_wdi = wdi;
        step[5] = ~step[5];
        arm_n = 1'b0;
        sb.push_back('{"arm_latency", 3});
        sb.push_back('{"active_alert5_seen", 0});
        sb.push_back('{"active_req_seen", 0});
        for (int n = 1; n <= 300; n++) begin
            tick(1);
            if (armed && arm_at < 0) arm_at = n;
            if (alert[5]) a5_seen++;
            if (req_shutdown) req_seen++;
            if (wdi) wdi_seen++;
            if (armed && wdi && !prev_wdi) begin
                if (r1 < 0) r1 = n; else if (r2 < 0) r2 = n;
            end
            prev_wdi = wdi;
            if (n % 50 == 0 && n < 300) step[5] = ~step[5];
        end
        obs = arm_at;   e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = a5_seen;  e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = req_seen; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
`ifdef STEP_WATCHDOG_WDI_EN
        sb.push_back('{"wdi_period_armed", 20});
        obs = r2 - r1;  e = sb.pop_front(); checks++;
        if (r1 < 0 || r2 < 0 || obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
`else
        sb.push_back('{"wdi_tied_low_armed", 0});
        obs = wdi_seen; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
`endif
    endtask

    task automatic test_trip();
        int a5_at = -1, req_at = -1, wdi_changes = 0, wdi_seen = 0, a5_after_toggle = -1;
        logic wdi_frozen = 1'b0;
        step[5] = ~step[5];
        sb.push_back('{"trip_alert5_cycle", 102});
        sb.push_back('{"trip_req_cycle", 103});
        sb.push_back('{"alert5_drop_after_toggle", 0});
        sb.push_back('{"req_held_after_toggles", 1});
        for (int n = 1; n <= 320; n++) begin
            tick(1);
            if (alert[5] && a5_at < 0) a5_at = n;
            if (req_shutdown && req_at < 0) req_at = n;
            if (n == 151) a5_after_toggle = int'(alert[5]);
            if (n == 104) wdi_frozen = wdi;
            if (n > 104 && n <= 304 && wdi != wdi_frozen) wdi_changes++;
            if (wdi) wdi_seen++;
            if (n % 20 == 0) step[4:0] = ~step[4:0];
            if (n == 150) step[5] = ~step[5];
        end
        obs = a5_at;            e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = req_at;           e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = a5_after_toggle;  e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = int'(req_shutdown); e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
`ifdef STEP_WATCHDOG_WDI_EN
        sb.push_back('{"wdi_frozen_changes", 0});
        obs = wdi_changes;      e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
`else
        sb.push_back('{"wdi_tied_low_tripped", 0});
        obs = wdi_seen + wdi_changes; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
`endif
    endtask

    task automatic test_clr_rearm();
        int arm_at = -1, req_at = -1;
        arm_n = 1'b1;
        tick(3);
        sb.push_back('{"req_latched_before_clr", 1});
        obs = int'(req_shutdown); e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        sb.push_back('{"clr_armed", 0});
        sb.push_back('{"clr_req", 0});
        obs = int'(armed);        e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = int'(req_shutdown); e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        tick(5);
        arm_n = 1'b0;
        sb.push_back('{"rearm_latency", 3});
        sb.push_back('{"retrip_latency", 4});
        for (int n = 1; n <= 20; n++) begin
            tick(1);
            if (armed && arm_at < 0) arm_at = n;
            if (req_shutdown && req_at < 0) req_at = n;
        end
        obs = arm_at; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = req_at; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
    endtask

    task automatic test_clr_collide();
        int early = 0, req_seen = 0;
        arm_n = 1'b1;
        tick(3);
        clr = 1'b1;
        step[5] = ~step[5];
        tick(1);
        clr = 1'b0;
        arm_n = 1'b0;
        tick(3);
        sb.push_back('{"collide_armed_before", 1});
        obs = int'(armed); e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        arm_n = 1'b1;
        step[5] = ~step[5];
        sb.push_back('{"collide_early_events", 0});
        sb.push_back('{"collide_alert5_rise", 1});
        for (int n = 1; n <= 101; n++) begin
            tick(1);
            if (alert[5] || !armed) early++;
        end
        tick(1);
        obs = early;          e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        obs = int'(alert[5]); e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        sb.push_back('{"collide_armed_after", 0});
        sb.push_back('{"collide_req_seen", 0});
        obs = int'(armed); e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
        if (req_shutdown) req_seen++;
        for (int n = 1; n <= 10; n++) begin
            tick(1);
            if (req_shutdown) req_seen++;
        end
        obs = req_seen; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.value); end
    endtask

    initial begin
        test_reset();
        test_arm_activity();
        test_trip();
        test_clr_rearm();
        test_clr_collide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "bench time limit expired");
    end

endmodule
`default_nettype wire
